spi_master_cfg: RTL

Parametrised full-duplex SPI master, the successor to the fixed 12-bit, mode-0 master.
- Adds configurable word width, sclk divider, CPOL/CPHA mode, bit order and MISO capture.
- Adds a valid/ready request handshake, plus a done pulse with the received word.
- Runs entirely on the system clock; sclk is a generated output, never used as a clock internally.
- Sits between a command source (test controller/register block) and an external SPI slave, or the team's spi_slave in loopback.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_clk_gen.sv | 60 ++++++
 rtl/spi_master_cfg.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the configurable SPI master.
// Holds the FSM state type, {CPOL,CPHA} mode encodings and a counter width helper.
// No logic of its own; imported by the master and its clock generator.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD
  } spi_state_e;

  // SPI modes encoded as {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Bits needed for a counter that must hold every value 0..max_val (at least 1 bit)
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// sclk generator: toggles sclk every HALF_PERIOD clk cycles while run is high.
// Latency: strobes are combinational and mark the clk cycle whose closing edge toggles sclk.
// Backpressure: none; clear parks sclk at its idle level and restarts the divider.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 6,
  parameter bit          CPOL        = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic sclk,
  output logic lead_stb,
  output logic trail_stb
);

  localparam int unsigned     DIV_W    = cnt_w(HALF_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             tick;

  // A toggle is due when the divider reaches its terminal count; leading means leaving idle
  assign tick      = run && (div_q == DIV_LAST);
  assign lead_stb  = tick && (sclk_q == CPOL);
  assign trail_stb = tick && (sclk_q != CPOL);
  assign sclk      = sclk_q;

  // Next divider count and sclk level
  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    if (clear) begin
      div_d  = '0;
      sclk_d = CPOL;
    end else if (run) begin
      if (tick) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Divider and sclk registers
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      sclk_q <= CPOL;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master with configurable width, divider, mode and bit order.
// Latency: cs high HALF_PERIOD*(2*DATA_W+2) cycles from the cycle after acceptance, then done.
// Backpressure: ready is high only in IDLE; new_data outside IDLE is dropped, not queued.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned HALF_PERIOD = 6,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_data,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  input  logic              miso,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              done
);

  if (DATA_W < 2 || HALF_PERIOD < 1) begin : g_bad_param
    $error("spi_master_cfg: DATA_W must be >= 2 and HALF_PERIOD >= 1");
  end

  localparam int unsigned       TMR_W     = cnt_w(HALF_PERIOD - 1);
  localparam int unsigned       EDGE_W    = cnt_w(2 * DATA_W);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(HALF_PERIOD - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);
  localparam logic [1:0]        MODE      = {CPOL, CPHA};
  // CPHA=1 modes drive mosi on leading edges and sample on trailing ones
  localparam bit                SHIFT_ON_LEAD = (MODE == MODE1) || (MODE == MODE3);
  localparam bit                IDLE_HIGH     = (MODE == MODE2) || (MODE == MODE3);

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [EDGE_W-1:0] edge_q, edge_d, edge_nxt;
  logic              mosi_q, mosi_d;
  logic              cs_q, cs_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              lead_stb, trail_stb;
  logic              do_sample, do_shift, last_edge;

  spi_clk_gen #(
    .HALF_PERIOD (HALF_PERIOD),
    .CPOL        (IDLE_HIGH)
  ) u_clk_gen (
    .clk       (clk),
    .reset     (reset),
    .run       (state_q == ST_XFER),
    .clear     (state_q == ST_IDLE),
    .sclk      (sclk),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb)
  );

  // Classify the current sclk strobe: which edge number it is and what it does to the data
  always_comb begin
    edge_nxt  = edge_q + EDGE_W'(1);
    last_edge = trail_stb && (edge_nxt == EDGE_LAST);
    do_sample = SHIFT_ON_LEAD ? trail_stb : lead_stb;
    do_shift  = SHIFT_ON_LEAD ? lead_stb : (trail_stb && !last_edge);
  end

  // Transfer sequencing: IDLE -> SETUP -> XFER -> HOLD -> IDLE
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    tmr_d   = tmr_q;
    edge_d  = edge_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    unique case (state_q)
      ST_IDLE: begin
        tmr_d  = '0;
        edge_d = '0;
        if (new_data) begin
          state_d = ST_SETUP;
          cs_d    = 1'b1;
          ready_d = 1'b0;
          rx_d    = '0;
          if (SHIFT_ON_LEAD) begin
            tx_d   = din;
            mosi_d = 1'b0;
          end else begin
            tx_d   = shift_out(din);
            mosi_d = first_bit(din);
          end
        end
      end
      ST_SETUP: begin
        if (tmr_q == TMR_LAST) begin
          state_d = ST_XFER;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_XFER: begin
        if (lead_stb || trail_stb) begin
          edge_d = edge_nxt;
        end
        if (do_sample) begin
          rx_d = shift_in(rx_q, miso);
        end
        if (do_shift) begin
          mosi_d = first_bit(tx_q);
          tx_d   = shift_out(tx_q);
        end
        if (last_edge) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_q == TMR_LAST) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
          cs_d    = 1'b0;
          mosi_d  = 1'b0;
          dout_d  = rx_q;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any transfer without a done
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      tmr_q   <= '0;
      edge_q  <= '0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      tmr_q   <= tmr_d;
      edge_q  <= edge_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;
  assign cs    = cs_q;
  assign mosi  = mosi_q;
  assign dout  = dout_q;
  assign done  = done_q;

endmodule
